gearbox_upsizing_nx: RTL and testbench
======================================

# gearbox_upsizing_nx

AXI-Stream width upsizer that packs `ratio` consecutive input beats of `nb` bits into one output word of `nb*ratio` bits. It generalises the fixed 2x gearbox to any ratio, puts a registered output stage on the wide side, and optionally closes packets early on `in_tlast` with a lane keep mask. It sits between narrow byte-lane producers and wide datapath consumers.

## Interface
- `n`, 5, bytes per input beat
- `nb`, `n*8`, input beat width in bits
- `ratio`, 4, input beats per output word; must be ≥ 2, with elaboration-time `$error` otherwise
- `aclk`  in  1  clock
- `aresetn`  in  1  reset, synchronous, active-low
- `in_tdata`  in  nb  input beat
- `in_tvalid`  in  1  input valid
- `in_tready`  out  1  input ready
- `in_tlast`  in  1  end of packet; ignored unless `GEARBOX_UPSIZE_TLAST_EN`
- `out_tdata`  out  nb*ratio  packed word, registered
- `out_tkeep`  out  ratio  lane-valid mask; bit i covers lane i, `out_tdata[nb*(i+1)-1 : nb*i]`
- `out_tvalid`  out  1  output valid, registered
- `out_tready`  in  1  output ready
- `out_tlast`  out  1  packet end, registered

## Operation
- Lane order: beat k of a word (k = 0 is the first accepted) goes to lane `ratio-1-k`. The first beat therefore lands in the most significant lane.
- Beat counter `cnt` is `$clog2(ratio)` bits wide and counts 0..ratio-1.
  - It increments on each input handshake (`in_tvalid & in_tready`).
  - It wraps to 0 when the word closes.
- Accumulator holds lanes ratio-1..1. Each accepted beat with `cnt < ratio-1` is written into its lane.
- Word closes on the handshake of the beat with `cnt == ratio-1`. With the macro, a beat with `in_tlast` also closes the word. On close:
  - the output register loads the accumulator plus the current beat, passed combinationally into its lane;
  - `out_tvalid` goes to 1;
  - `cnt` goes to 0;
  - the accumulator is cleared to 0.
- Output register holds its contents while `out_tvalid & ~out_tready`. It drops `out_tvalid` after a handshake unless a new word closes in the same cycle.
- Simultaneous output handshake and word close: the new word replaces the old one and `out_tvalid` stays 1 with no bubble.
- Flow control:
  - Without the macro: `in_tready = (cnt != ratio-1) | ~out_tvalid | out_tready`. Accumulation continues while the output stalls, and only the closing beat is held off.
  - With the macro: `in_tready = ~out_tvalid | out_tready`.
  - `in_tready` never depends on `in_tvalid` or `in_tdata`.
- Reset values:
  - `out_tvalid` = 0, `out_tlast` = 0, `out_tkeep` = 0, `out_tdata` = 0;
  - `cnt` = 0, accumulator = 0.
- Reset mid-word: the partial word is discarded, and the first beat after reset starts a new word in lane ratio-1.

## Timing
- Latency: closing beat accepted in cycle t → word valid on `out_tdata` in cycle t+1.
- Throughput: 1 input beat per cycle, i.e. 1 output word per `ratio` cycles, while `out_tready` is held high.
- Backpressure: `out_tvalid`, `out_tdata`, `out_tkeep` and `out_tlast` stay stable from assertion until the handshake.

## Configuration
- `GEARBOX_UPSIZE_TLAST_EN` defined:
  - `in_tlast` closes a word early;
  - `out_tlast` = 1 on that word;
  - `out_tkeep` has ones for the filled lanes, ratio-1 down to ratio-1-k, and zeros below them;
  - unfilled lanes of `out_tdata` are 0;
  - `in_tready` uses the macro rule above.
- `GEARBOX_UPSIZE_TLAST_EN` not defined:
  - `in_tlast` is ignored;
  - `out_tlast` is always 0;
  - `out_tkeep` loads all-ones with every word;
  - words always hold exactly `ratio` beats.

## Test plan
Bench configuration: `n=1`, `ratio=4`, so `nb=8`.

- Streaming: beats 0x11, 0x22, 0x33, 0x44, 0x55..0x88 with `out_tready=1` → words `0x11223344` then `0x55667788`; each word's valid is asserted 1 cycle after its 4th beat; `in_tready` stays 1 throughout.
- Backpressure: `out_tready=0` while 8 beats are offered → first word held stable. Without the macro, beats 5–7 are accepted and beat 8 stalls with `in_tready=0`. Releasing `out_tready` delivers both words in order with no loss.
- Simultaneous: a word is pending and beat 4 of the next word arrives in the cycle `out_tready` rises → `out_tvalid` stays 1 and the next cycle shows the new word.
- Early close (macro defined): beats 0xAA, 0xBB with `in_tlast` on 0xBB → `out_tdata = 0xAABB0000`, `out_tkeep = 4'b1100`, `out_tlast = 1`. The next beat starts in lane 3.
- Mid-word reset: 2 beats accepted, then `aresetn=0` for 1 cycle → all outputs 0 and the partial word is discarded. Beats 0x01..0x04 then yield `0x01020304`.
- Ratio sweep: `ratio` = 2, 3 and 8 with a random valid/ready pattern → the scoreboard matches MSB-first packing, with no drops or duplicates.

Source files
------------

// File: rtl/gearbox_upsizing_nx.sv
// AXI-Stream width upsizer: packs `ratio` narrow beats MSB-lane-first into one registered wide word.
// Optional early packet close on in_tlast with lane keep mask when GEARBOX_UPSIZE_TLAST_EN is defined.
module gearbox_upsizing_nx #(
    parameter int n     = 5,
    parameter int nb    = n * 8,
    parameter int ratio = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [nb-1:0]         in_tdata,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    input  logic                  in_tlast,
    output logic [nb*ratio-1:0]   out_tdata,
    output logic [ratio-1:0]      out_tkeep,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  out_tlast
);

    localparam int CW = (ratio > 2) ? $clog2(ratio) : 1;
    localparam int WW = nb * ratio;
    localparam logic [CW-1:0] LAST_CNT = CW'(ratio - 1);

    generate
        if (ratio < 2) begin : g_bad_ratio
            $error("gearbox_upsizing_nx: ratio must be >= 2");
        end
    endgenerate

    logic [CW-1:0]      cnt_r;
    logic [WW-nb-1:0]   acc_r;
    logic [WW-1:0]      beat_word_s;
    logic [WW-1:0]      word_s;
    logic [ratio-1:0]   keep_s;
    logic               in_tready_s;
    logic               in_hs_s;
    logic               out_hs_s;
    logic               close_s;
    logic               last_s;
    logic [WW-1:0]      out_tdata_r;
    logic [ratio-1:0]   out_tkeep_r;
    logic               out_tvalid_r;
    logic               out_tlast_r;

`ifdef GEARBOX_UPSIZE_TLAST_EN
    assign last_s      = in_tlast;
    // The closing beat can be any beat, so every beat waits for a free output slot.
    assign in_tready_s = ~out_tvalid_r | out_tready;
`else
    logic unused_tlast_s;
    assign unused_tlast_s = in_tlast;
    assign last_s      = 1'b0;
    // Only the word-closing beat needs the output register; earlier beats keep filling.
    assign in_tready_s = (cnt_r != LAST_CNT) | ~out_tvalid_r | out_tready;
`endif

    assign in_hs_s  = in_tvalid & in_tready_s;
    assign out_hs_s = out_tvalid_r & out_tready;
    assign close_s  = in_hs_s & ((cnt_r == LAST_CNT) | last_s);

    // Steer the current beat into lane ratio-1-cnt and build the keep mask for the closing word.
    always_comb begin
        beat_word_s = {WW{1'b0}};
        keep_s      = {ratio{1'b0}};
        for (int i = 0; i < ratio; i++) begin
            if (int'(cnt_r) == (ratio - 1 - i)) begin
                beat_word_s[i*nb +: nb] = in_tdata;
            end else begin
                beat_word_s[i*nb +: nb] = {nb{1'b0}};
            end
`ifdef GEARBOX_UPSIZE_TLAST_EN
            if (int'(cnt_r) >= (ratio - 1 - i)) begin
                keep_s[i] = 1'b1;
            end else begin
                keep_s[i] = 1'b0;
            end
`else
            keep_s[i] = 1'b1;
`endif
        end
        word_s = {acc_r, {nb{1'b0}}} | beat_word_s;
    end

    // Beat counter and accumulator for lanes ratio-1..1.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {(WW-nb){1'b0}};
        end else if (close_s) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {(WW-nb){1'b0}};
        end else if (in_hs_s) begin
            cnt_r <= cnt_r + CW'(1);
            acc_r <= acc_r | beat_word_s[WW-1:nb];
        end else begin
            cnt_r <= cnt_r;
            acc_r <= acc_r;
        end
    end

    // Output register: a closing word wins over a handshake so there is no bubble.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_tdata_r  <= {WW{1'b0}};
            out_tkeep_r  <= {ratio{1'b0}};
            out_tvalid_r <= 1'b0;
            out_tlast_r  <= 1'b0;
        end else if (close_s) begin
            out_tdata_r  <= word_s;
            out_tkeep_r  <= keep_s;
            out_tvalid_r <= 1'b1;
            out_tlast_r  <= last_s;
        end else if (out_hs_s) begin
            out_tvalid_r <= 1'b0;
        end else begin
            out_tvalid_r <= out_tvalid_r;
        end
    end

    assign in_tready  = in_tready_s;
    assign out_tdata  = out_tdata_r;
    assign out_tkeep  = out_tkeep_r;
    assign out_tvalid = out_tvalid_r;
    assign out_tlast  = out_tlast_r;

endmodule

// File: tb/tb_gearbox_upsizing_nx.sv
// Directed bench for gearbox_upsizing_nx (n=1, ratio=4) plus a random ratio sweep (2, 3, 8).
module tb_gearbox_upsizing_nx;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic        in_tlast;
    logic [31:0] out_tdata;
    logic [3:0]  out_tkeep;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic        sweep_go = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 aclk = ~aclk;

    gearbox_upsizing_nx #(.n(1), .ratio(4)) u_dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tlast   (in_tlast),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Present one beat, wait (bounded) for ready, and complete the handshake.
    task automatic send(input logic [7:0] d, input logic last);
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        #1;
        for (int i = 0; i < 50 && !in_tready; i++) begin
            @(posedge aclk);
            #2;
        end
        check("send_ready", 64'(in_tready), 64'd1);
        step();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        for (int i = 0; i < 20 && !out_tvalid; i++) step();
        check({tag, "_valid"}, 64'(out_tvalid), 64'd1);
        check({tag, "_data"},  64'(out_tdata),  64'(d));
        check({tag, "_keep"},  64'(out_tkeep),  64'(k));
        check({tag, "_last"},  64'(out_tlast),  64'(l));
    endtask

    // Random valid/ready sweep at other ratios against a shift-in packing model.
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int R = (g == 0) ? 2 : ((g == 1) ? 3 : 8);
        logic           sw_rstn, sw_v, sw_ir, sw_ov, sw_or, sw_ol, sw_done;
        logic [7:0]     sw_d;
        logic [8*R-1:0] sw_od;
        logic [R-1:0]   sw_ok;

        gearbox_upsizing_nx #(.n(1), .ratio(R)) u_sw (
            .aclk       (aclk),
            .aresetn    (sw_rstn),
            .in_tdata   (sw_d),
            .in_tvalid  (sw_v),
            .in_tready  (sw_ir),
            .in_tlast   (1'b0),
            .out_tdata  (sw_od),
            .out_tkeep  (sw_ok),
            .out_tvalid (sw_ov),
            .out_tready (sw_or),
            .out_tlast  (sw_ol)
        );

        initial begin
            logic [63:0] q[$];
            logic [63:0] acc;
            logic [7:0]  seq;
            int          k;
            logic        hs;
            sw_rstn = 1'b0; sw_v = 1'b0; sw_d = 8'h00; sw_or = 1'b0; sw_done = 1'b0;
            acc = 64'd0; seq = 8'h01; k = 0;
            wait (sweep_go);
            repeat (2) @(posedge aclk);
            #1 sw_rstn = 1'b1;
            for (int c = 0; c < 400; c++) begin
                if (c < 340) begin
                    if (!sw_v) sw_v = ($urandom_range(0, 3) != 0);
                    sw_or = ($urandom_range(0, 2) != 0);
                end else begin
                    sw_v  = 1'b0;
                    sw_or = 1'b1;
                end
                sw_d = seq;
                #1;
                if (sw_ov && sw_or) begin
                    if (q.size() == 0) begin
                        check("sweep_dup", 64'(sw_ov), 64'd0);
                    end else begin
                        check("sweep_word", 64'(sw_od), q.pop_front());
                        check("sweep_keep", 64'(sw_ok), 64'((1 << R) - 1));
                        check("sweep_last", 64'(sw_ol), 64'd0);
                    end
                end
                hs = sw_v && sw_ir;
                if (hs) begin
                    acc = (acc << 8) | 64'(sw_d);
                    seq++;
                    k++;
                    if (k == R) begin
                        q.push_back(acc);
                        acc = 64'd0;
                        k = 0;
                    end
                end
                @(posedge aclk);
                #1;
                if (hs) sw_v = 1'b0;
            end
            check("sweep_drain", 64'(q.size()), 64'd0);
            sw_done = 1'b1;
        end
    end

    logic [7:0] s_beats [8];

    initial begin
        s_beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        aresetn = 1'b0; in_tvalid = 1'b0; in_tdata = 8'h00; in_tlast = 1'b0; out_tready = 1'b0;
        step();
        step();
        check("rst_valid", 64'(out_tvalid), 64'd0);
        check("rst_data",  64'(out_tdata),  64'd0);
        check("rst_keep",  64'(out_tkeep),  64'd0);
        check("rst_last",  64'(out_tlast),  64'd0);
        aresetn = 1'b1;
        out_tready = 1'b1;
        step();
        check("rst_in_ready", 64'(in_tready), 64'd1);

        // Streaming: one beat per cycle, valid one cycle after each fourth beat.
        in_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_tdata = s_beats[i];
            #1;
            check("stream_in_ready", 64'(in_tready), 64'd1);
            check("stream_valid", 64'(out_tvalid), (i == 4) ? 64'd1 : 64'd0);
            if (i == 4) check("stream_word0", 64'(out_tdata), 64'h11223344);
            step();
        end
        in_tvalid = 1'b0;
        expect_word("stream_word1", 32'h55667788, 4'hF, 1'b0);
        step();
        check("stream_idle", 64'(out_tvalid), 64'd0);

        // Backpressure with the output stalled.
        out_tready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), 1'b0);
        check("bp_valid", 64'(out_tvalid), 64'd1);
        check("bp_word0", 64'(out_tdata), 64'hA1A2A3A4);
`ifndef GEARBOX_UPSIZE_TLAST_EN
        for (int i = 4; i < 7; i++) send(8'hA1 + 8'(i), 1'b0);
        in_tdata = 8'hA8; in_tvalid = 1'b1;
        #1;
        check("bp_stall_ready", 64'(in_tready), 64'd0);
        step();
        step();
        check("bp_stall_ready2", 64'(in_tready), 64'd0);
        check("bp_hold_data", 64'(out_tdata), 64'hA1A2A3A4);
        check("bp_hold_valid", 64'(out_tvalid), 64'd1);
        out_tready = 1'b1;
        #1;
        check("simul_in_ready", 64'(in_tready), 64'd1);
        step();
        in_tvalid = 1'b0;
        check("simul_valid", 64'(out_tvalid), 64'd1);
        check("simul_word1", 64'(out_tdata), 64'hA5A6A7A8);
        step();
        check("simul_idle", 64'(out_tvalid), 64'd0);
        // in_tlast has no effect in this build.
        send(8'hB1, 1'b0); send(8'hB2, 1'b1); send(8'hB3, 1'b0); send(8'hB4, 1'b0);
        expect_word("tlast_ignored", 32'hB1B2B3B4, 4'hF, 1'b0);
        step();
`else
        in_tdata = 8'hA5; in_tvalid = 1'b1;
        #1;
        check("bp_stall_ready", 64'(in_tready), 64'd0);
        step();
        check("bp_hold_data", 64'(out_tdata), 64'hA1A2A3A4);
        out_tready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_tready), 64'd1);
        step();
        in_tvalid = 1'b0;
        check("bp_drained", 64'(out_tvalid), 64'd0);
        for (int i = 5; i < 8; i++) send(8'hA1 + 8'(i), 1'b0);
        expect_word("bp_word1", 32'hA5A6A7A8, 4'hF, 1'b0);
        step();
        // Early close.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        expect_word("early", 32'hAABB0000, 4'b1100, 1'b1);
        for (int i = 1; i < 5; i++) send(8'(i), 1'b0);
        expect_word("after_early", 32'h01020304, 4'hF, 1'b0);
        step();
        // Pending word, then a single tlast beat as out_tready rises.
        out_tready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hC1 + 8'(i), 1'b0);
        in_tdata = 8'h5A; in_tlast = 1'b1; in_tvalid = 1'b1;
        #1;
        check("simul_stall", 64'(in_tready), 64'd0);
        out_tready = 1'b1;
        #1;
        check("simul_in_ready", 64'(in_tready), 64'd1);
        step();
        in_tvalid = 1'b0; in_tlast = 1'b0;
        expect_word("simul", 32'h5A000000, 4'b1000, 1'b1);
        step();
        check("simul_idle", 64'(out_tvalid), 64'd0);
`endif

        // Mid-word reset discards the partial word and the pending output.
        out_tready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hD1 + 8'(i), 1'b0);
`ifndef GEARBOX_UPSIZE_TLAST_EN
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
`endif
        check("mrst_pending", 64'(out_tvalid), 64'd1);
        aresetn = 1'b0;
        step();
        check("mrst_valid", 64'(out_tvalid), 64'd0);
        check("mrst_data",  64'(out_tdata),  64'd0);
        check("mrst_keep",  64'(out_tkeep),  64'd0);
        check("mrst_last",  64'(out_tlast),  64'd0);
        aresetn = 1'b1;
        out_tready = 1'b1;
        for (int i = 1; i < 5; i++) send(8'(i), 1'b0);
        expect_word("mrst_word", 32'h01020304, 4'hF, 1'b0);
        step();
        check("mrst_idle", 64'(out_tvalid), 64'd0);

        sweep_go = 1'b1;
        for (int i = 0; i < 2000 && !(g_sw[0].sw_done && g_sw[1].sw_done && g_sw[2].sw_done); i++) step();
        check("sweep_finished", 64'(g_sw[0].sw_done && g_sw[1].sw_done && g_sw[2].sw_done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
